// File: rtl/alu_issue_stage_if.sv
// Bundle of ID-side and EX-side signals around the ALU issue register.
// The illegal_count signal exists only when ILLEGAL_TRAP_EN is defined.
interface alu_issue_stage_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              wr_en;
    logic [4:0]        wr_reg;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] store_data;
    logic              illegal;
`ifdef ILLEGAL_TRAP_EN
    logic [15:0]       illegal_count;
`endif

    modport master (
        output flush, in_valid, instr, pc_plus4, rs_data, rt_data, out_ready,
        input  in_ready, out_valid, alu_op, alu_a, alu_b, wr_en, wr_reg,
               mem_rd, mem_wr, store_data, illegal
`ifdef ILLEGAL_TRAP_EN
             , illegal_count
`endif
    );

    modport slave (
        input  flush, in_valid, instr, pc_plus4, rs_data, rt_data, out_ready,
        output in_ready, out_valid, alu_op, alu_a, alu_b, wr_en, wr_reg,
               mem_rd, mem_wr, store_data, illegal
`ifdef ILLEGAL_TRAP_EN
             , illegal_count
`endif
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes the 31-instruction MIPS subset into ALU op/operands.
// Define ILLEGAL_TRAP_EN to flag unrecognised encodings and count them (illegal_count).
`ifndef ALU_ADDU
`define ALU_SLL   6'h00
`define ALU_SRL   6'h02
`define ALU_SRA   6'h03
`define ALU_SLLV  6'h04
`define ALU_SRLV  6'h06
`define ALU_SRAV  6'h07
`define ALU_JR    6'h08
`define ALU_ORI   6'h0D
`define ALU_XORI  6'h0E
`define ALU_LUI   6'h0F
`define ALU_ADD   6'h20
`define ALU_ADDU  6'h21
`define ALU_SUB   6'h22
`define ALU_SUBU  6'h23
`define ALU_AND   6'h24
`define ALU_OR    6'h25
`define ALU_XOR   6'h26
`define ALU_NOR   6'h27
`define ALU_SLT   6'h2A
`define ALU_SLTU  6'h2B
`endif

module alu_issue_stage #(
    parameter int DATA_W   = 32,
    parameter int LINK_REG = 31
) (
    input logic               clk,
    input logic               rst,
    alu_issue_stage_if.slave  bus
);
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign opcode = bus.instr[31:26];
    assign rs     = bus.instr[25:21];
    assign rt     = bus.instr[20:16];
    assign rd     = bus.instr[15:11];
    assign shamt  = bus.instr[10:6];
    assign funct  = bus.instr[5:0];
    assign imm    = bus.instr[15:0];

    logic [DATA_W-1:0] imm_sx, imm_zx, shamt_zx;
    assign imm_sx   = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zx   = {{(DATA_W-16){1'b0}}, imm};
    assign shamt_zx = {{(DATA_W-5){1'b0}}, shamt};

    logic [5:0]        op_d,   op_q;
    logic [DATA_W-1:0] a_d,    a_q;
    logic [DATA_W-1:0] b_d,    b_q;
    logic              wen_d,  wen_q;
    logic [4:0]        wreg_d, wreg_q;
    logic              mrd_d,  mrd_q;
    logic              mwr_d,  mwr_q;
    logic [DATA_W-1:0] sd_d,   sd_q;
    logic              ill_d;
    logic              vld_q;

    // Defaults describe the NOP that unrecognised encodings decode to.
    always_comb begin
        op_d   = `ALU_ADDU;
        a_d    = '0;
        b_d    = '0;
        wen_d  = 1'b0;
        wreg_d = 5'd0;
        mrd_d  = 1'b0;
        mwr_d  = 1'b0;
        sd_d   = '0;
        ill_d  = 1'b0;
        case (opcode)
            6'h00: begin
                a_d    = bus.rs_data;
                b_d    = bus.rt_data;
                wreg_d = rd;
                wen_d  = 1'b1;
                case (funct)
                    6'h20: op_d = `ALU_ADD;
                    6'h21: op_d = `ALU_ADDU;
                    6'h22: op_d = `ALU_SUB;
                    6'h23: op_d = `ALU_SUBU;
                    6'h24: op_d = `ALU_AND;
                    6'h25: op_d = `ALU_OR;
                    6'h26: op_d = `ALU_XOR;
                    6'h27: op_d = `ALU_NOR;
                    6'h2A: op_d = `ALU_SLT;
                    6'h2B: op_d = `ALU_SLTU;
                    6'h00: begin op_d = `ALU_SLL; a_d = shamt_zx; end
                    6'h02: begin op_d = `ALU_SRL; a_d = shamt_zx; end
                    6'h03: begin op_d = `ALU_SRA; a_d = shamt_zx; end
                    6'h04: op_d = `ALU_SLLV;
                    6'h06: op_d = `ALU_SRLV;
                    6'h07: op_d = `ALU_SRAV;
                    6'h08: begin
                        op_d   = `ALU_JR;
                        b_d    = '0;
                        wreg_d = 5'd0;
                        wen_d  = 1'b0;
                    end
                    default: begin
                        a_d    = '0;
                        b_d    = '0;
                        wreg_d = 5'd0;
                        wen_d  = 1'b0;
                        ill_d  = 1'b1;
                    end
                endcase
            end
            6'h08: begin op_d = `ALU_ADD;  a_d = bus.rs_data; b_d = imm_sx; wreg_d = rt; wen_d = 1'b1; end
            6'h09: begin op_d = `ALU_ADDU; a_d = bus.rs_data; b_d = imm_sx; wreg_d = rt; wen_d = 1'b1; end
            6'h0A: begin op_d = `ALU_SLT;  a_d = bus.rs_data; b_d = imm_sx; wreg_d = rt; wen_d = 1'b1; end
            6'h0B: begin op_d = `ALU_SLTU; a_d = bus.rs_data; b_d = imm_sx; wreg_d = rt; wen_d = 1'b1; end
            6'h0C: begin op_d = `ALU_AND;  a_d = bus.rs_data; b_d = imm_zx; wreg_d = rt; wen_d = 1'b1; end
            6'h0D: begin op_d = `ALU_ORI;  a_d = bus.rs_data; b_d = imm_zx; wreg_d = rt; wen_d = 1'b1; end
            6'h0E: begin op_d = `ALU_XORI; a_d = bus.rs_data; b_d = imm_zx; wreg_d = rt; wen_d = 1'b1; end
            6'h0F: begin op_d = `ALU_LUI;  b_d = imm_zx; wreg_d = rt; wen_d = 1'b1; end
            6'h23: begin
                a_d = bus.rs_data; b_d = imm_sx; wreg_d = rt; wen_d = 1'b1; mrd_d = 1'b1;
            end
            6'h2B: begin
                a_d = bus.rs_data; b_d = imm_sx; mwr_d = 1'b1; sd_d = bus.rt_data;
            end
            6'h04, 6'h05: begin op_d = `ALU_SUBU; a_d = bus.rs_data; b_d = bus.rt_data; end
            6'h02: ;
            6'h03: begin
                a_d    = bus.pc_plus4;
                b_d    = DATA_W'(4);
                wreg_d = 5'(LINK_REG);
                wen_d  = 1'b1;
            end
            default: ill_d = 1'b1;
        endcase
        if (wreg_d == 5'd0) wen_d = 1'b0;
    end

    logic xfer;
    assign bus.in_ready = !vld_q || bus.out_ready;
    assign xfer         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            op_q   <= `ALU_ADDU;
            a_q    <= '0;
            b_q    <= '0;
            wen_q  <= 1'b0;
            wreg_q <= 5'd0;
            mrd_q  <= 1'b0;
            mwr_q  <= 1'b0;
            sd_q   <= '0;
        end else if (bus.flush) begin
            vld_q <= 1'b0;
        end else if (bus.in_ready) begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                op_q   <= op_d;
                a_q    <= a_d;
                b_q    <= b_d;
                wen_q  <= wen_d;
                wreg_q <= wreg_d;
                mrd_q  <= mrd_d;
                mwr_q  <= mwr_d;
                sd_q   <= sd_d;
            end
        end
    end

    assign bus.out_valid  = vld_q;
    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.wr_en      = wen_q;
    assign bus.wr_reg     = wreg_q;
    assign bus.mem_rd     = mrd_q;
    assign bus.mem_wr     = mwr_q;
    assign bus.store_data = sd_q;

`ifdef ILLEGAL_TRAP_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        ill_q;
    logic [15:0] ill_cnt_q;

    // Flushed instructions never count; the flag follows the same load rule as the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ill_q     <= 1'b0;
            ill_cnt_q <= 16'd0;
        end else if (!bus.flush && xfer) begin
            ill_q <= ill_d;
            if (ill_d) ill_cnt_q <= sat_inc16(ill_cnt_q);
        end
    end

    assign bus.illegal       = ill_q;
    assign bus.illegal_count = ill_cnt_q;
`else
    logic unused_ill;
    assign unused_ill  = ill_d ^ xfer;
    assign bus.illegal = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; covers ILLEGAL_TRAP_EN builds as well.
module tb_alu_issue_stage;
    localparam logic [5:0] C_SLL = 6'h00, C_SLLV = 6'h04, C_JR = 6'h08, C_ORI = 6'h0D,
                           C_LUI = 6'h0F, C_ADD = 6'h20, C_ADDU = 6'h21, C_SUBU = 6'h23;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_W(32)) bus ();
    alu_issue_stage #(.DATA_W(32), .LINK_REG(31)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.rs_data  = rs;
        bus.rt_data  = rt;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.instr = '0; bus.pc_plus4 = '0;
        bus.rs_data = '0; bus.rt_data = '0; bus.out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_op", bus.alu_op, C_ADDU);
        check("rst_a", bus.alu_a, 0);
        check("rst_wen", bus.wr_en, 0);
        check("rst_inrdy", bus.in_ready, 1);
        check("rst_illegal", bus.illegal, 0);
`ifdef ILLEGAL_TRAP_EN
        check("rst_icnt", bus.illegal_count, 0);
`endif
        rst = 1'b0;

        issue(rtype(1, 2, 3, 0, 6'h21), 5, 7);
        check("addu_valid", bus.out_valid, 1);
        check("addu_op", bus.alu_op, C_ADDU);
        check("addu_a", bus.alu_a, 5);
        check("addu_b", bus.alu_b, 7);
        check("addu_wreg", bus.wr_reg, 3);
        check("addu_wen", bus.wr_en, 1);

        issue(rtype(0, 2, 4, 3, 6'h00), 0, 1);
        check("sll_op", bus.alu_op, C_SLL);
        check("sll_a", bus.alu_a, 3);
        check("sll_b", bus.alu_b, 1);
        check("sll_wreg", bus.wr_reg, 4);

        issue(rtype(3, 2, 4, 0, 6'h04), 3, 1);
        check("sllv_op", bus.alu_op, C_SLLV);
        check("sllv_a", bus.alu_a, 3);
        check("sllv_b", bus.alu_b, 1);

        issue(itype(6'h08, 1, 5, 16'hFFFF), 5, 0);
        check("addi_op", bus.alu_op, C_ADD);
        check("addi_b", bus.alu_b, 32'hFFFF_FFFF);
        check("addi_wreg", bus.wr_reg, 5);

        issue(itype(6'h0D, 1, 5, 16'hFFFF), 5, 0);
        check("ori_op", bus.alu_op, C_ORI);
        check("ori_b", bus.alu_b, 32'h0000_FFFF);

        issue(itype(6'h0F, 0, 6, 16'h1234), 9, 0);
        check("lui_op", bus.alu_op, C_LUI);
        check("lui_a", bus.alu_a, 0);
        check("lui_b", bus.alu_b, 32'h0000_1234);

        issue(itype(6'h23, 1, 7, 16'hFFFC), 32'h40, 0);
        check("lw_b", bus.alu_b, 32'hFFFF_FFFC);
        check("lw_mrd", bus.mem_rd, 1);
        check("lw_wreg", bus.wr_reg, 7);

        issue(itype(6'h2B, 1, 7, 16'h0008), 32'h40, 32'hDEAD);
        check("sw_mwr", bus.mem_wr, 1);
        check("sw_wen", bus.wr_en, 0);
        check("sw_sd", bus.store_data, 32'hDEAD);
        check("sw_b", bus.alu_b, 8);

        issue(itype(6'h04, 1, 2, 16'h0010), 32'h11, 32'h22);
        check("beq_op", bus.alu_op, C_SUBU);
        check("beq_b", bus.alu_b, 32'h22);
        check("beq_wen", bus.wr_en, 0);

        issue(rtype(1, 2, 0, 0, 6'h21), 1, 2);
        check("r0_wen", bus.wr_en, 0);

        issue(rtype(9, 0, 0, 0, 6'h08), 32'h200, 0);
        check("jr_op", bus.alu_op, C_JR);
        check("jr_a", bus.alu_a, 32'h200);
        check("jr_wen", bus.wr_en, 0);

        bus.pc_plus4 = 32'h100;
        issue({6'h03, 26'h0}, 0, 0);
        check("jal_a", bus.alu_a, 32'h100);
        check("jal_b", bus.alu_b, 4);
        check("jal_wreg", bus.wr_reg, 31);
        check("jal_wen", bus.wr_en, 1);

        // Stall: hold X while Y waits at the input.
        issue(rtype(1, 2, 3, 0, 6'h21), 32'h11, 32'h22);
        bus.out_ready = 1'b0;
        bus.instr = rtype(1, 2, 8, 0, 6'h23); bus.rs_data = 32'h33; bus.rt_data = 32'h44;
        #1;
        check("stall_inrdy", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_a", bus.alu_a, 32'h11);
            check("stall_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("resume_a", bus.alu_a, 32'h33);
        check("resume_op", bus.alu_op, C_SUBU);
        check("resume_wreg", bus.wr_reg, 8);
        bus.in_valid = 1'b0;
        tick();
        check("drain_valid", bus.out_valid, 0);

        // Flush with stage full and a transfer pending.
        issue(rtype(1, 2, 3, 0, 6'h21), 1, 1);
        bus.flush = 1'b1;
        issue(rtype(1, 2, 4, 0, 6'h21), 2, 2);
        check("flush_valid", bus.out_valid, 0);
        bus.flush = 1'b0;

        // Flush and reset while stalled.
        issue(rtype(1, 2, 3, 0, 6'h21), 1, 1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b1;
        tick();
        check("flush_stall_valid", bus.out_valid, 0);
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        issue(rtype(1, 2, 3, 0, 6'h21), 1, 1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; rst = 1'b1;
        tick();
        check("rst_stall_valid", bus.out_valid, 0);
        rst = 1'b0; bus.out_ready = 1'b1;

        // Illegal opcode 0x3F: first copy flushed, second survives.
        bus.flush = 1'b1;
        issue({6'h3F, 26'h123}, 5, 6);
        check("ill_flushed_valid", bus.out_valid, 0);
        bus.flush = 1'b0;
        issue({6'h3F, 26'h123}, 5, 6);
        bus.in_valid = 1'b0;
        check("ill_valid", bus.out_valid, 1);
        check("ill_wen", bus.wr_en, 0);
        check("ill_a", bus.alu_a, 0);
        check("ill_op", bus.alu_op, C_ADDU);
`ifdef ILLEGAL_TRAP_EN
        check("ill_flag", bus.illegal, 1);
        check("ill_count", bus.illegal_count, 1);
`else
        check("ill_flag", bus.illegal, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID→EX pipeline stage that produces everything the EX-stage ALU consumes: the 6-bit ALU operation code, operand A, operand B, plus the write-back target.
- Decodes the 31-instruction MIPS subset from the instruction word and the already-forwarded rs/rt values.
- Registers the result with a valid/ready handshake, stall and flush.
- The ALU operation code uses the `ALU_* encodings in macro.vh.

Parameters:
- DATA_W, 32, operand/data width.
- LINK_REG, 31, destination register for jal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill in-flight and incoming instruction (branch/jump redirect)
- in_valid  in  1  ID has an instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  instruction word
- pc_plus4  in  DATA_W  PC+4 of instr
- rs_data  in  DATA_W  forwarded rs value
- rt_data  in  DATA_W  forwarded rt value
- out_valid  out  1  EX inputs valid
- out_ready  in  1  EX accepts
- alu_op  out  6  `ALU_* code
- alu_a  out  DATA_W  ALU operand A
- alu_b  out  DATA_W  ALU operand B
- wr_en  out  1  register write-back enable
- wr_reg  out  5  write-back register number
- mem_rd  out  1  lw
- mem_wr  out  1  sw
- store_data  out  DATA_W  rt_data for sw
- illegal  out  1  unrecognised encoding (feature only; else 0)

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, alu_op=`ALU_ADDU, alu_a=alu_b=0, wr_en=0, wr_reg=0, mem_rd=mem_wr=0, store_data=0, illegal=0. Counters cleared.
- in_ready = !out_valid || out_ready (combinational). Handshake transfer occurs when in_valid && in_ready.
- Latency 1: decoded fields appear on the cycle after the transfer.
- Output regs hold while out_valid && !out_ready.
- Flush priority:
  - flush=1 → next out_valid=0, and the incoming instruction is dropped.
  - flush outranks transfer, and rst outranks flush.
- Stage is a single register; there is no FSM beyond the valid bit (EMPTY/FULL).
- Decode, R-type (op=0, by funct):
  - add/addu/sub/subu/and/or/xor/nor/slt/sltu: A=rs, B=rt, wr_reg=rd, wr_en=1.
  - sll/srl/sra: A=zero-extended shamt (instr[10:6]), B=rt.
  - sllv/srlv/srav: A=rs, B=rt.
  - jr: `ALU_JR, A=rs, B=0, wr_en=0.
- Decode, I-type:
  - addi/addiu/slti/sltiu: A=rs, B=sign-extended imm16, wr_reg=rt.
  - andi: `ALU_AND, zero-extended imm. ori/xori use `ALU_ORI/`ALU_XORI with zero-extended imm.
  - lui: `ALU_LUI, A=0, B=zero-extended imm (ALU shifts by 16).
  - lw: `ALU_ADDU, A=rs, B=sign-extended imm, mem_rd=1, wr_reg=rt.
  - sw: `ALU_ADDU, A=rs, B=sign-extended imm, mem_wr=1, wr_en=0, store_data=rt_data.
  - beq/bne: `ALU_SUBU, A=rs, B=rt, wr_en=0.
- Decode, J-type:
  - j: `ALU_ADDU, A=B=0, wr_en=0.
  - jal: `ALU_ADDU, A=pc_plus4, B=4 (link = PC+8), wr_reg=LINK_REG, wr_en=1.
- wr_en is forced 0 whenever the destination register is 0.
- Width: all extensions to DATA_W. Overflow detection belongs to the ALU, not this stage.
- Unrecognised op/funct: decoded as NOP (`ALU_ADDU, A=B=0, all enables 0), out_valid still 1.
- Reset or flush while stalled discards the held instruction.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- With it defined:
  - Unrecognised encodings raise illegal=1 alongside the NOP fields.
  - A 16-bit saturating illegal_count output (extra port) increments once per accepted illegal instruction.
  - Cleared by rst; not incremented for flushed instructions.
- Without it: the illegal port is tied 0 and illegal_count is absent.

Test Plan:
- Reset, then addu $3,$1,$2 (rs=5, rt=7), out_ready=1 → next cycle out_valid=1, alu_op=`ALU_ADDU, alu_a=5, alu_b=7, wr_reg=3, wr_en=1.
- sll $4,$2,3 (rt=0x1) → alu_op=`ALU_SLL, alu_a=3, alu_b=1. sllv with rs=3 → same operands, `ALU_SLLV.
- addi $5,$1,-1 → alu_b=0xFFFFFFFF. ori $5,$1,0xFFFF → alu_b=0x0000FFFF. lui $6,0x1234 → alu_a=0, alu_b=0x00001234.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs frozen. Then out_ready=1 → next instruction accepted, none lost or duplicated.
- flush asserted together with an accepted instruction while the stage is FULL → next cycle out_valid=0. jal with pc_plus4=0x100 → alu_a=0x100, alu_b=4, wr_reg=31.
- Feature on: op=0x3F issued twice, one of them flushed → illegal=1 on the surviving one, illegal_count=1. Feature off: out_valid=1, wr_en=0, illegal=0.
